// File: rtl/pipe_if_stage.sv
// Instruction fetch stage with IF/ID register for the 5-stage MIPS pipe.
// Fetches over a req/ack imem port and honours load-use stalls and delay slots.
module pipe_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    input  logic        wpcir,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] pc_out,
    output logic [31:0] dinst,
    output logic [31:0] dpc4,
    output logic        dvalid
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] hold_inst;
    logic [31:0] redir_pc;
    logic        redir_pend;

    logic        avail;
    logic        live_br;
    logic [31:0] inst;
    logic [31:0] tgt;
    logic [31:0] pc4;

    always_comb begin
        avail   = ((state == FETCH) && imem_ack) || (state == HOLD);
        inst    = (state == HOLD) ? hold_inst : imem_rdata;
        live_br = dvalid && (pcsource != 2'b00);
        pc4     = pc + 32'd4;
        tgt     = pc4;
        unique case (pcsource)
            2'b01:   tgt = bpc;
            2'b10:   tgt = rpc;
            2'b11:   tgt = jpc;
            default: tgt = pc4;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            dinst      <= NOP_INST;
            dpc4       <= 32'd0;
            dvalid     <= 1'b0;
            redir_pend <= 1'b0;
            redir_pc   <= 32'd0;
            hold_inst  <= 32'd0;
        end else if (wpcir && avail) begin
            dinst      <= inst;
            dpc4       <= pc4;
            dvalid     <= 1'b1;
            state      <= FETCH;
            redir_pend <= 1'b0;
            if (redir_pend)
                pc <= redir_pc;
            else if (live_br)
                pc <= tgt;
            else
                pc <= pc4;
        end else if (wpcir) begin
            dinst  <= NOP_INST;
            dvalid <= 1'b0;
            // branch leaves ID before its delay slot is fetched; remember target
            if (live_br) begin
                redir_pend <= 1'b1;
                redir_pc   <= tgt;
            end
        end else if ((state == FETCH) && imem_ack) begin
            hold_inst <= imem_rdata;
            state     <= HOLD;
        end
    end

    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;
    assign pc_out    = pc;

endmodule
